// File: rtl/dual_digit_entry_ctrl_if.sv
// Bus between the entry controller and its environment: key/clear/switch inputs
// plus the load strobes and status that feed the two-digit BCD store.
interface dual_digit_entry_ctrl_if;
    logic       KEYn;
    logic       CLR;
    logic [3:0] BCD;
    logic       LOAD_A;
    logic       LOAD_B;
    logic [3:0] DATA;
    logic       SEL;
    logic       ERR;
    logic [1:0] COUNT;

    modport master (
        output KEYn, CLR, BCD,
        input  LOAD_A, LOAD_B, DATA, SEL, ERR, COUNT
    );

    modport slave (
        input  KEYn, CLR, BCD,
        output LOAD_A, LOAD_B, DATA, SEL, ERR, COUNT
    );
endinterface

// File: rtl/dual_digit_entry_ctrl.sv
// Debounces the entry key, validates the BCD switches and emits single-cycle
// load strobes alternating between digit A and digit B; CLR blanks both digits.
module dual_digit_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    dual_digit_entry_ctrl_if.slave   bus
);

    localparam int                SYNC_STAGES = 2;
    localparam int                CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_REL = 1'b1;

    localparam logic [3:0] BLANK_CODE  = 4'hF;

    // sync_chain[0] is the raw pin; each stage resets to the released level.
    logic [SYNC_STAGES:0] sync_chain;
    logic                 key_sync;

    assign sync_chain[0] = bus.KEYn;
    assign key_sync      = sync_chain[SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi = gi + 1) begin : g_sync
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    sync_chain[gi+1] <= 1'b1;
                end else begin
                    sync_chain[gi+1] <= sync_chain[gi];
                end
            end
        end
    endgenerate

    logic             key_level_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic             press_evt_reg;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_level_reg <= 1'b1;
            deb_cnt_reg   <= '0;
            press_evt_reg <= 1'b0;
        end else begin
            press_evt_reg <= 1'b0;
            if (key_sync != key_level_reg) begin
                if (deb_cnt_reg == CNT_LAST) begin
                    key_level_reg <= key_sync;
                    deb_cnt_reg   <= '0;
                    press_evt_reg <= ~key_sync;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + CNT_ONE;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

    logic [0:0] state_reg,  state_next;
    logic       load_a_reg, load_a_next;
    logic       load_b_reg, load_b_next;
    logic [3:0] data_reg,   data_next;
    logic       sel_reg,    sel_next;
    logic       err_reg,    err_next;
    logic [1:0] count_reg,  count_next;

    always_comb begin
        state_next  = state_reg;
        load_a_next = 1'b0;
        load_b_next = 1'b0;
        data_next   = data_reg;
        sel_next    = sel_reg;
        err_next    = err_reg;
        count_next  = count_reg;

        // Clear wins over a coincident press; that press is simply lost.
        if (bus.CLR) begin
            load_a_next = 1'b1;
            load_b_next = 1'b1;
            data_next   = BLANK_CODE;
            sel_next    = 1'b1;
            err_next    = 1'b0;
            count_next  = 2'd0;
            state_next  = key_level_reg ? ST_IDLE : ST_WAIT_REL;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (press_evt_reg) begin
                        if (bus.BCD <= 4'd9) begin
                            data_next   = bus.BCD;
                            load_a_next = sel_reg;
                            load_b_next = ~sel_reg;
                            sel_next    = ~sel_reg;
                            if (count_reg != 2'd2) begin
                                count_next = count_reg + 2'd1;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                        state_next = ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (key_level_reg) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg  <= ST_IDLE;
            load_a_reg <= 1'b0;
            load_b_reg <= 1'b0;
            data_reg   <= BLANK_CODE;
            sel_reg    <= 1'b1;
            err_reg    <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            state_reg  <= state_next;
            load_a_reg <= load_a_next;
            load_b_reg <= load_b_next;
            data_reg   <= data_next;
            sel_reg    <= sel_next;
            err_reg    <= err_next;
            count_reg  <= count_next;
        end
    end

    assign bus.LOAD_A = load_a_reg;
    assign bus.LOAD_B = load_b_reg;
    assign bus.DATA   = data_reg;
    assign bus.SEL    = sel_reg;
    assign bus.ERR    = err_reg;
    assign bus.COUNT  = count_reg;

endmodule

// File: tb/tb_dual_digit_entry_ctrl.sv
// Directed bench for dual_digit_entry_ctrl with DEBOUNCE_CYCLES=4: entry order,
// bounce rejection, invalid BCD, clear behaviour and asynchronous reset.
module tb_dual_digit_entry_ctrl;

    logic CLK;
    logic RSTn;

    dual_digit_entry_ctrl_if bus();

    dual_digit_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    int cyc = 0;
    int na = 0, nb = 0, nclr = 0, n_consec = 0;
    int last_a_cyc = -1;
    logic prev_entry = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.LOAD_A && bus.LOAD_B) begin
            nclr <= nclr + 1;
        end else if (bus.LOAD_A) begin
            na         <= na + 1;
            last_a_cyc <= cyc;
        end else if (bus.LOAD_B) begin
            nb <= nb + 1;
        end
        if ((bus.LOAD_A ^ bus.LOAD_B) && prev_entry) n_consec <= n_consec + 1;
        prev_entry <= bus.LOAD_A ^ bus.LOAD_B;
    end

    task automatic hold_key(input logic level, input int n);
        bus.KEYn = level;
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [3:0] bcd, input int n);
        bus.BCD = bcd;
        hold_key(1'b0, n);
        hold_key(1'b1, 12);
        $display("press BCD=%0h: DATA=%0h SEL=%0b COUNT=%0d ERR=%0b",
                 bcd, bus.DATA, bus.SEL, bus.COUNT, bus.ERR);
    endtask

    int a0, b0, c0, e0_cyc;

    initial begin
        RSTn     = 1'b1;
        bus.KEYn = 1'b1;
        bus.CLR  = 1'b0;
        bus.BCD  = 4'd0;
        #1 RSTn = 1'b0;
        #1;
        check("rst_load_a", bus.LOAD_A, 0);
        check("rst_load_b", bus.LOAD_B, 0);
        check("rst_data",   bus.DATA,   4'hF);
        check("rst_sel",    bus.SEL,    1);
        check("rst_err",    bus.ERR,    0);
        check("rst_count",  bus.COUNT,  0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);

        // First entry with latency check: strobe lands on edge e0+6.
        a0 = na; b0 = nb;
        e0_cyc = cyc + 1;
        press(4'd5, 10);
        check("e1_a_cnt",   na - a0, 1);
        check("e1_b_cnt",   nb - b0, 0);
        check("e1_latency", last_a_cyc - e0_cyc, 6);
        check("e1_data",    bus.DATA,  5);
        check("e1_sel",     bus.SEL,   0);
        check("e1_count",   bus.COUNT, 1);

        a0 = na; b0 = nb;
        press(4'd7, 10);
        check("e2_b_cnt", nb - b0, 1);
        check("e2_a_cnt", na - a0, 0);
        check("e2_data",  bus.DATA,  7);
        check("e2_sel",   bus.SEL,   1);
        check("e2_count", bus.COUNT, 2);

        a0 = na; b0 = nb;
        press(4'd2, 10);
        check("e3_a_cnt", na - a0, 1);
        check("e3_data",  bus.DATA,  2);
        check("e3_sel",   bus.SEL,   0);
        check("e3_count", bus.COUNT, 2);

        // Bounce: 2-cycle toggles, then hold with a 3-cycle chatter.
        a0 = na; b0 = nb;
        bus.BCD = 4'd1;
        for (int i = 0; i < 8; i++) begin
            hold_key(1'b0, 2);
            hold_key(1'b1, 2);
        end
        hold_key(1'b0, 8);
        hold_key(1'b1, 3);
        hold_key(1'b0, 8);
        hold_key(1'b1, 12);
        $display("bounce: A strobes=%0d B strobes=%0d DATA=%0h", na - a0, nb - b0, bus.DATA);
        check("bnc_entries", (na - a0) + (nb - b0), 1);
        check("bnc_b_cnt",   nb - b0, 1);
        check("bnc_data",    bus.DATA, 1);

        // Clear with key released.
        c0 = nclr;
        bus.CLR = 1'b1;
        @(negedge CLK);
        bus.CLR = 1'b0;
        repeat (2) @(negedge CLK);
        $display("clear: DATA=%0h SEL=%0b COUNT=%0d", bus.DATA, bus.SEL, bus.COUNT);
        check("clr_strobes", nclr - c0, 1);
        check("clr_sel",     bus.SEL,   1);
        check("clr_count",   bus.COUNT, 0);

        // Invalid BCD, then a valid entry keeps ERR sticky.
        a0 = na; b0 = nb;
        press(4'hB, 10);
        check("inv_entries", (na - a0) + (nb - b0), 0);
        check("inv_err",     bus.ERR,   1);
        check("inv_sel",     bus.SEL,   1);
        check("inv_count",   bus.COUNT, 0);
        check("inv_data",    bus.DATA,  4'hF);
        a0 = na;
        press(4'd3, 10);
        check("v3_a_cnt", na - a0, 1);
        check("v3_data",  bus.DATA, 3);
        check("v3_err",   bus.ERR,  1);

        // Two entries since clear, then clear while the key is held.
        press(4'd4, 10);
        check("v4_count", bus.COUNT, 2);
        bus.BCD = 4'd6;
        hold_key(1'b0, 10);
        check("ovr_data",  bus.DATA,  6);
        check("ovr_count", bus.COUNT, 2);
        bus.CLR = 1'b1;
        @(negedge CLK);
        bus.CLR = 1'b0;
        $display("clear held: LOAD_A=%0b LOAD_B=%0b DATA=%0h", bus.LOAD_A, bus.LOAD_B, bus.DATA);
        check("clh_load_a", bus.LOAD_A, 1);
        check("clh_load_b", bus.LOAD_B, 1);
        check("clh_data",   bus.DATA,   4'hF);
        check("clh_sel",    bus.SEL,    1);
        check("clh_count",  bus.COUNT,  0);
        check("clh_err",    bus.ERR,    0);
        a0 = na; b0 = nb;
        hold_key(1'b0, 10);
        hold_key(1'b1, 12);
        check("clh_no_load", (na - a0) + (nb - b0), 0);
        a0 = na;
        press(4'd8, 10);
        check("clh_next_a", na - a0, 1);
        check("clh_next_d", bus.DATA, 8);

        // Collision: CLR sampled on the press_evt cycle (edge e0+6).
        a0 = na; b0 = nb; c0 = nclr;
        bus.BCD  = 4'd9;
        bus.KEYn = 1'b0;
        repeat (6) @(negedge CLK);
        bus.CLR = 1'b1;
        @(negedge CLK);
        bus.CLR = 1'b0;
        hold_key(1'b0, 6);
        hold_key(1'b1, 12);
        $display("collision: entries=%0d clears=%0d DATA=%0h", (na - a0) + (nb - b0), nclr - c0, bus.DATA);
        check("col_entries", (na - a0) + (nb - b0), 0);
        check("col_clears",  nclr - c0, 1);
        check("col_data",    bus.DATA,  4'hF);
        check("col_count",   bus.COUNT, 0);

        // Asynchronous reset landing inside a strobe cycle.
        bus.BCD  = 4'd9;
        bus.KEYn = 1'b0;
        repeat (7) @(negedge CLK);
        check("pre_rst_load_a", bus.LOAD_A, 1);
        #1 RSTn = 1'b0;
        #1;
        $display("mid reset: LOAD_A=%0b DATA=%0h SEL=%0b", bus.LOAD_A, bus.DATA, bus.SEL);
        check("mrst_load_a", bus.LOAD_A, 0);
        check("mrst_data",   bus.DATA,   4'hF);
        check("mrst_sel",    bus.SEL,    1);
        check("mrst_count",  bus.COUNT,  0);
        bus.KEYn = 1'b1;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);

        check("no_consec_strobes", n_consec, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
